scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  level-sampled request to begin a scan; acted on only in IDLE.
REQ-005 stop  input  1  abort request; acted on in any state.
REQ-006 single_shot  input  1  1 = one pass over the enabled channels; 0 = continuous wrap.
REQ-007 chan_mask  input  8  channel enables; bit i enables channel i.
REQ-008 dwell  input  DWELL_W  cycles to hold each channel; 0 is treated as 1.
REQ-009 sel  output  3  registered channel index; drives the downstream 3-to-8 decoder `in` port.
REQ-010 sel_en  output  1  registered; drives the decoder `enable` port.
REQ-011 busy  output  1  registered; high while not in IDLE.
REQ-012 done  output  1  registered one-cycle pulse when a single-shot pass completes.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DWELL and GAP. GAP is present only under REQ-027.
- IDLE: all outputs are 0.
- DWELL: sel_en=1 and busy=1.
- GAP: sel_en=0 and busy=1.
REQ-014 chan_mask, dwell and single_shot SHALL be latched when start is accepted. Later changes to these inputs SHALL have no effect until the next start.
REQ-015 A start in IDLE with latched mask == 0 SHALL be ignored: the block stays in IDLE and no done pulse is generated.
REQ-016 A start accepted in cycle N SHALL give, in cycle N+1, sel_en=1, busy=1, and sel = index of the lowest set mask bit.
REQ-017 Each selected channel SHALL be held for exactly D = max(dwell,1) consecutive cycles.
REQ-018 The next channel SHALL be the next set mask bit above the current index, searched with wrap-around from 7 to 0. Masked channels are skipped with zero cycles of cost.
REQ-019 If the mask has a single set bit, that channel SHALL be re-selected each period. In continuous mode sel_en stays high without a gap, except as required by REQ-027.
REQ-020 Single-shot completion:
- A pass ends when the dwell on the highest set bit ends.
- In the following cycle: done=1, sel_en=0, busy=0, state=IDLE.
REQ-021 In continuous mode the scan SHALL wrap after the highest set bit back to the lowest set bit and run until stop. done is never asserted in continuous mode.
REQ-022 stop asserted in any non-IDLE state SHALL give, in the next cycle: IDLE, sel_en=0, busy=0, done=0.
REQ-023 If start and stop are asserted in the same cycle, stop SHALL win and the block remains in or enters IDLE.
REQ-024 start while busy SHALL be ignored.
REQ-025 The dwell counter SHALL be DWELL_W bits wide and SHALL never wrap. dwell = all-ones gives 2^DWELL_W-1 cycles.

Reset
REQ-026 While rst_n=0, and asynchronously on its assertion (including mid-scan), the block SHALL force:
- state=IDLE
- sel=0, sel_en=0, busy=0, done=0
- dwell counter and all latched configuration cleared
After reset release, the first start is honoured on the first rising edge.

Configuration
REQ-027 Macro SCAN_SEQ_GAP_EN selects break-before-make behaviour.
- Defined: one GAP cycle (sel_en=0, sel holds the outgoing index) is inserted between every two consecutive dwells, including a re-selection of the same channel and the wrap in continuous mode. No GAP is inserted before the first dwell or after the last.
- Not defined: no GAP state exists, and dwells are back-to-back.

Structure
REQ-028 A shared package scan_seq_pkg SHALL hold:
- the state enum (IDLE, DWELL, GAP)
- NUM_CH=8 and SEL_W=3
REQ-029 The wrap-around next-set-bit search SHALL be a combinational sub-module, scan_next_chan. Its inputs are the mask and the current index; its outputs are the next index and a wrapped flag.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Mask 0xFF, dwell 2, single_shot=1, start at cycle 0 -> sel 0..7 each high for 2 cycles (sel_en cycles 1-16), then done=1 at cycle 17 and busy=0.
- Mask 0x81, dwell 0, continuous -> sel alternates 0,7,0,7 every cycle; stop -> sel_en=0 the next cycle; done is never asserted.
- Mask 0x00, start -> busy stays 0 and no done pulse.
- Mask 0x24, dwell 3, start and stop in the same cycle -> stays in IDLE; after a later start, sel=2 for 3 cycles, then sel=5 for 3 cycles.
- rst_n pulsed low mid-dwell on channel 4 -> outputs are 0 immediately, without waiting for a clock edge, and stay 0 after release until the next start.
- With SCAN_SEQ_GAP_EN, mask 0x03, dwell 1, single-shot -> sel_en pattern 1,0,1, then done.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the channel scan sequencer.
package scan_seq_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Index of the lowest set bit; callers guarantee the mask is non-zero.
   function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
      logic [SEL_W-1:0] idx;
      idx = {SEL_W{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = SEL_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_next_chan.sv
// Wrap-around search for the next enabled channel above the current index.
module scan_next_chan
   import scan_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur_idx,
   output logic [SEL_W-1:0]  next_idx,
   output logic              wrapped
);

   logic             found_s;
   logic [SEL_W-1:0] cand_s;

   // Offset NUM_CH lands back on cur_idx, so a single-bit mask re-selects itself.
   always_comb begin
      next_idx = cur_idx;
      found_s  = 1'b0;
      cand_s   = cur_idx;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand_s = cur_idx + SEL_W'(i);
         if (!found_s && mask[cand_s]) begin
            found_s  = 1'b1;
            next_idx = cand_s;
         end else begin
            found_s  = found_s;
         end
      end
      wrapped = found_s && (next_idx <= cur_idx);
   end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 3-to-8 decoder with per-channel dwell.
// Define SCAN_SEQ_GAP_EN for a break-before-make GAP cycle between dwells.
module scan_sequencer
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               single_shot,
   input  logic [NUM_CH-1:0]  chan_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_en,
   output logic               busy,
   output logic               done
);

   localparam logic [DWELL_W-1:0] ONE_D = DWELL_W'(1);

   state_t             state_r, state_n;
   logic [DWELL_W-1:0] cnt_r, cnt_n;
   logic [DWELL_W-1:0] dwell_r, dwell_n;
   logic [NUM_CH-1:0]  mask_r, mask_n;
   logic               single_r, single_n;
   logic [SEL_W-1:0]   sel_n;
   logic               done_n;
   logic [SEL_W-1:0]   next_s;
   logic               wrapped_s;
   logic [DWELL_W-1:0] dwell_eff_s;

   scan_next_chan u_next (
      .mask     (mask_r),
      .cur_idx  (sel),
      .next_idx (next_s),
      .wrapped  (wrapped_s)
   );

   assign dwell_eff_s = (dwell == {DWELL_W{1'b0}}) ? ONE_D : dwell;

   // Next-state, next-output and configuration-latch logic.
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      dwell_n  = dwell_r;
      mask_n   = mask_r;
      single_n = single_r;
      sel_n    = sel;
      done_n   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !stop && (chan_mask != {NUM_CH{1'b0}})) begin
               state_n  = DWELL;
               mask_n   = chan_mask;
               dwell_n  = dwell_eff_s;
               single_n = single_shot;
               sel_n    = lowest_set(chan_mask);
               cnt_n    = dwell_eff_s - ONE_D;
            end else begin
               state_n  = IDLE;
               sel_n    = {SEL_W{1'b0}};
            end
         end
         DWELL: begin
            if (stop) begin
               state_n = IDLE;
               sel_n   = {SEL_W{1'b0}};
            end else if (cnt_r != {DWELL_W{1'b0}}) begin
               cnt_n   = cnt_r - ONE_D;
            end else if (single_r && wrapped_s) begin
               // Dwell on the highest enabled channel just ended.
               state_n = IDLE;
               sel_n   = {SEL_W{1'b0}};
               done_n  = 1'b1;
            end else begin
`ifdef SCAN_SEQ_GAP_EN
               state_n = GAP;
`else
               sel_n   = next_s;
               cnt_n   = dwell_r - ONE_D;
`endif
            end
         end
`ifdef SCAN_SEQ_GAP_EN
         GAP: begin
            if (stop) begin
               state_n = IDLE;
               sel_n   = {SEL_W{1'b0}};
            end else begin
               state_n = DWELL;
               sel_n   = next_s;
               cnt_n   = dwell_r - ONE_D;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            sel_n   = {SEL_W{1'b0}};
         end
      endcase
   end

   // State, configuration and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= {DWELL_W{1'b0}};
         dwell_r  <= {DWELL_W{1'b0}};
         mask_r   <= {NUM_CH{1'b0}};
         single_r <= 1'b0;
         sel      <= {SEL_W{1'b0}};
         sel_en   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         dwell_r  <= dwell_n;
         mask_r   <= mask_n;
         single_r <= single_n;
         sel      <= sel_n;
         sel_en   <= (state_n == DWELL);
         busy     <= (state_n != IDLE);
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed scenarios plus randomized scans
// compared cycle by cycle against a channel-list reference model.
module tb_scan_sequencer;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic       busy;
      logic       done;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       single_shot = 1'b0;
   logic [7:0] chan_mask = 8'h00;
   logic [7:0] dwell = 8'h00;
   logic [2:0] sel;
   logic       sel_en;
   logic       busy;
   logic       done;

   int   tests = 0;
   int   fails = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   scan_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .single_shot (single_shot),
      .chan_mask   (chan_mask),
      .dwell       (dwell),
      .sel         (sel),
      .sel_en      (sel_en),
      .busy        (busy),
      .done        (done)
   );

   function automatic obs_t mk(input logic [2:0] s, input logic e, input logic b, input logic d);
      obs_t o;
      o = {s, e, b, d};
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int step, input obs_t e);
      obs_t a;
      a = {sel, sel_en, busy, done};
      tests++;
      assert (a === e) else begin
         fails++;
         $error("FAIL %s step %0d: got sel=%0d en=%0b busy=%0b done=%0b, want sel=%0d en=%0b busy=%0b done=%0b",
                tag, step, a.sel, a.en, a.busy, a.done, e.sel, e.en, e.busy, e.done);
      end
   endtask

   // Expected outputs for the n cycles following an accepted start.
   task automatic model(input logic [7:0] m, input logic [7:0] dw, input logic ss, input int n);
      int chs[$];
      int d;
      int pos;
      exp_q.delete();
      d = (dw == 8'd0) ? 1 : int'(dw);
      for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
      if (chs.size() > 0) begin
         if (ss) begin
            foreach (chs[k]) begin
`ifdef SCAN_SEQ_GAP_EN
               if (k > 0) exp_q.push_back(mk(3'(chs[k-1]), 1'b0, 1'b1, 1'b0));
`endif
               repeat (d) exp_q.push_back(mk(3'(chs[k]), 1'b1, 1'b1, 1'b0));
            end
            exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b1));
         end else begin
            pos = 0;
            while (exp_q.size() < n) begin
`ifdef SCAN_SEQ_GAP_EN
               if (exp_q.size() > 0)
                  exp_q.push_back(mk(3'(chs[(pos + chs.size() - 1) % chs.size()]), 1'b0, 1'b1, 1'b0));
`endif
               repeat (d) exp_q.push_back(mk(3'(chs[pos]), 1'b1, 1'b1, 1'b0));
               pos = (pos + 1) % chs.size();
            end
         end
      end
      while (exp_q.size() < n) exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
      while (exp_q.size() > n) void'(exp_q.pop_back());
   endtask

   // Start a scan, scramble config (and re-assert start) while busy, stop if continuous.
   task automatic run_scan(input string tag, input logic [7:0] m, input logic [7:0] dw,
                           input logic ss, input int n);
      model(m, dw, ss, n);
      chan_mask   = m;
      dwell       = dw;
      single_shot = ss;
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < n; j++) begin
         check(tag, j, exp_q[j]);
         chan_mask   = 8'($urandom);
         dwell       = 8'($urandom);
         single_shot = 1'($urandom);
         start       = exp_q[j].busy ? 1'($urandom_range(0, 1)) : 1'b0;
         if (j == n - 1 && !ss) stop = 1'b1;
         tick();
      end
      if (!ss) check({tag, "_stop"}, n, mk(3'd0, 1'b0, 1'b0, 1'b0));
      stop  = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      obs_t zero;
      logic [7:0] m;
      logic [7:0] dw;
      logic       ss;
      int         n;
      zero = mk(3'd0, 1'b0, 1'b0, 1'b0);

      tick();
      tick();
      check("reset", 0, zero);
      rst_n = 1'b1;

      run_scan("ff_d2_single", 8'hFF, 8'd2, 1'b1, 20);
      run_scan("81_d0_cont", 8'h81, 8'd0, 1'b0, 10);
      run_scan("mask0", 8'h00, 8'd2, 1'b1, 5);

      chan_mask = 8'h24; dwell = 8'd3; single_shot = 1'b1;
      start = 1'b1; stop = 1'b1;
      tick();
      check("start_stop", 0, zero);
      start = 1'b0; stop = 1'b0;
      tick();
      check("start_stop", 1, zero);
      run_scan("24_d3_single", 8'h24, 8'd3, 1'b1, 9);

      chan_mask = 8'h10; dwell = 8'd5; single_shot = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_pre", 0, mk(3'd4, 1'b1, 1'b1, 1'b0));
      tick();
      check("rst_pre", 1, mk(3'd4, 1'b1, 1'b1, 1'b0));
      #2 rst_n = 1'b0;
      #1 check("rst_async", 0, zero);
      tick();
      check("rst_hold", 0, zero);
      rst_n = 1'b1;
      tick();
      check("rst_after", 0, zero);
      tick();
      check("rst_after", 1, zero);
      run_scan("post_rst", 8'h5A, 8'd1, 1'b1, 10);

      run_scan("dwell_max", 8'h02, 8'hFF, 1'b1, 258);
      run_scan("single_bit_cont", 8'h08, 8'd2, 1'b0, 12);

      for (int r = 0; r < 10; r++) begin
         m  = 8'($urandom_range(1, 255));
         dw = 8'($urandom_range(0, 4));
         ss = 1'($urandom_range(0, 1));
         n  = ss ? ($countones(m) * (dw == 8'd0 ? 1 : int'(dw)) + $countones(m) + 3) : 30;
         run_scan("random", m, dw, ss, n);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
